// File: rtl/uart_ctrl.sv
// uart_ctrl: memory-mapped UART with a TX holding register plus shifter and an RX FIFO.
// Optional feature macro UART_LOOPBACK_EN feeds txd_o back into the receiver for self-test.
`timescale 1ns/1ps
module uart_ctrl #(
    parameter int CLK_DIV  = 434,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic [1:0]  sel_i,
    input  logic        rd_i,
    input  logic        we_i,
    output logic        ack_o,
    input  logic        rxd_i,
    output logic        txd_o,
    output logic        irq_o
);

    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'((CLK_DIV / 2) - 1);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    logic            ack_q, ack_d;
    logic [31:0]     data_q, data_d;
    logic            irq_q, irq_d;
    logic            txd_q, txd_d;
    logic [7:0]      hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
    tx_state_e       tx_state_q, tx_state_d;
    logic [15:0]     tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    rx_state_e       rx_state_q, rx_state_d;
    logic [15:0]     rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            ovf_q, ovf_d, ferr_q, ferr_d;
    logic [7:0]      mem_q [RX_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic req_s, is_tx_s, stall_s, accept_s, rd_acc_s, tx_load_s, rx_rd_s;
    logic pop_s, push_s, full_s, ovf_set_s, ferr_set_s, rx_push_req_s;
    logic tx_take_s, tx_busy_s, rx_in_s, fall_s;
    logic [7:0] rx_count8_s;
    logic unused_s;

`ifdef UART_LOOPBACK_EN
    assign rx_in_s  = txd_q;
    assign unused_s = ^{sel_i, addr_i[31:3], addr_i[1:0], data_i[31:8], rxd_i};
`else
    assign rx_in_s  = rxd_i;
    assign unused_s = ^{sel_i, addr_i[31:3], addr_i[1:0], data_i[31:8]};
`endif

    // Writes stall only against a full holding register; writes win if rd and we are both high.
    assign req_s       = rd_i | we_i;
    assign is_tx_s     = addr_i[2];
    assign stall_s     = we_i & is_tx_s & hold_full_q;
    assign accept_s    = req_s & ~ack_q & ~stall_s;
    assign rd_acc_s    = accept_s & ~we_i;
    assign tx_load_s   = accept_s & we_i & is_tx_s;
    assign rx_rd_s     = rd_acc_s & ~is_tx_s;
    assign pop_s       = rx_rd_s & (cnt_q != CW'(0));
    assign full_s      = (cnt_q == CW'(RX_DEPTH));
    assign push_s      = rx_push_req_s & (~full_s | pop_s);
    assign ovf_set_s   = rx_push_req_s & full_s & ~pop_s;
    assign tx_busy_s   = (tx_state_q != TX_IDLE);
    assign rx_count8_s = 8'(cnt_q);
    assign fall_s      = prev_q & ~sync2_q;

    // Bus response, sticky flags and holding register.
    always_comb begin
        ack_d = accept_s | (ack_q & req_s);
        if (rd_acc_s) begin
            if (is_tx_s) begin
                data_d = {16'd0, rx_count8_s, 6'd0, tx_busy_s, hold_full_q};
            end else begin
                data_d = {pop_s, 21'd0, ovf_q, ferr_q, (pop_s ? mem_q[rd_ptr_q] : 8'd0)};
            end
        end else begin
            data_d = data_q;
        end
        ovf_d  = (ovf_q & ~rx_rd_s) | ovf_set_s;
        ferr_d = (ferr_q & ~rx_rd_s) | ferr_set_s;
        if (tx_load_s) begin
            hold_d      = data_i[7:0];
            hold_full_d = 1'b1;
        end else begin
            hold_d      = hold_q;
            hold_full_d = hold_full_q & ~tx_take_s;
        end
    end

    // RX FIFO pointers, occupancy and interrupt.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        irq_d = (cnt_d != CW'(0));
    end

    // TX FSM; txd is computed from the next state so the line moves with the state change.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_take_s  = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (hold_full_q) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = 16'd0;
                    tx_shift_d = hold_q;
                    tx_take_s  = 1'b1;
                    txd_d      = 1'b0;
                end else begin
                    txd_d      = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt_q == DIV_M1) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = 16'd0;
                    tx_bit_d   = 3'd0;
                    txd_d      = tx_shift_q[0];
                end else begin
                    tx_cnt_d   = tx_cnt_q + 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == DIV_M1) begin
                    tx_cnt_d = 16'd0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b1, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == DIV_M1) begin
                    tx_cnt_d = 16'd0;
                    if (hold_full_q) begin
                        tx_state_d = TX_START;
                        tx_shift_d = hold_q;
                        tx_take_s  = 1'b1;
                        txd_d      = 1'b0;
                    end else begin
                        tx_state_d = TX_IDLE;
                        txd_d      = 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                txd_d      = 1'b1;
            end
        endcase
    end

    // RX synchroniser and FSM; start is re-checked mid-bit to reject glitches.
    always_comb begin
        sync1_d       = rx_in_s;
        sync2_d       = sync1_q;
        prev_d        = sync2_q;
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        rx_push_req_s = 1'b0;
        ferr_set_s    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (fall_s) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = 16'd0;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_M1) begin
                    rx_cnt_d   = 16'd0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == DIV_M1) begin
                    rx_cnt_d   = 16'd0;
                    rx_shift_d = {sync2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == DIV_M1) begin
                    rx_cnt_d      = 16'd0;
                    rx_state_d    = RX_IDLE;
                    rx_push_req_s = sync2_q;
                    ferr_set_s    = ~sync2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // State registers; reset idles both lines high and empties every buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q       <= 1'b0;
            data_q      <= 32'd0;
            irq_q       <= 1'b0;
            txd_q       <= 1'b1;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= 16'd0;
            tx_bit_q    <= 3'd0;
            tx_shift_q  <= 8'd0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= 16'd0;
            rx_bit_q    <= 3'd0;
            rx_shift_q  <= 8'd0;
            ovf_q       <= 1'b0;
            ferr_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < RX_DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
        end else begin
            ack_q       <= ack_d;
            data_q      <= data_d;
            irq_q       <= irq_d;
            txd_q       <= txd_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            ovf_q       <= ovf_d;
            ferr_q      <= ferr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= rx_shift_q;
            end
        end
    end

    assign ack_o  = ack_q;
    assign data_o = data_q;
    assign irq_o  = irq_q;
    assign txd_o  = txd_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl: expected read words and serial bits are queued at stimulus time
// and popped when the DUT produces them. Build with UART_LOOPBACK_EN to run the loopback step.
`timescale 1ns/1ps
module tb_uart_ctrl;
    localparam int CLK_DIV = 8;
    localparam int RX_DEPTH = 4;
    localparam logic [31:0] RX_ADDR = 32'hFFFF_FE08;
    localparam logic [31:0] TX_ADDR = 32'hFFFF_FE0C;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr_i, data_i, data_o;
    logic [1:0]  sel_i;
    logic        rd_i, we_i, ack_o, rxd_i, txd_o, irq_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ack_cyc = 0;
    logic [31:0] exp_q[$];

    uart_ctrl #(.CLK_DIV(CLK_DIV), .RX_DEPTH(RX_DEPTH)) dut (
        .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
        .sel_i(sel_i), .rd_i(rd_i), .we_i(we_i), .ack_o(ack_o),
        .rxd_i(rxd_i), .txd_o(txd_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_sb(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) e = 32'hDEAD_BEEF;
        else e = exp_q.pop_front();
        check(tag, obs, e);
    endtask

    task automatic push_frame(input logic [7:0] b);
        exp_q.push_back(32'd0);
        for (int i = 0; i < 8; i++) exp_q.push_back({31'd0, b[i]});
        exp_q.push_back(32'd1);
    endtask

    // lat counts falling clock edges from the request; an un-stalled ack is seen on the 2nd.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int lat);
        @(posedge clk); #1;
        addr_i = a; data_i = d; we_i = 1'b1; lat = 0;
        while (lat < 300) begin
            @(negedge clk); lat++;
            if (ack_o) break;
        end
        ack_cyc = cyc;
        check("wr_ack", {31'd0, ack_o}, 32'd1);
        @(posedge clk); #1;
        we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        int lat;
        @(posedge clk); #1;
        addr_i = a; rd_i = 1'b1; lat = 0;
        while (lat < 300) begin
            @(negedge clk); lat++;
            if (ack_o) break;
        end
        d = data_o;
        check("rd_ack_lat", lat, 32'd2);
        @(posedge clk); #1;
        rd_i = 1'b0;
    endtask

    task automatic tx_frames(input int n, output int s1);
        int k;
        k = 0;
        while (k < 400) begin
            @(negedge clk); k++;
            if (txd_o == 1'b0) break;
        end
        s1 = cyc;
        check("tx_start_seen", {31'd0, txd_o}, 32'd0);
        repeat (4) @(negedge clk);
        for (int i = 0; i < n * 10; i++) begin
            check_sb($sformatf("tx_bit%0d", i), {31'd0, txd_o});
            if (i != n * 10 - 1) repeat (CLK_DIV) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd_i = f[i];
            repeat (CLK_DIV) @(posedge clk);
            #1;
        end
        rxd_i = 1'b1;
    endtask

    initial begin
        int lat, l1, l2, l3, s1, a3;
        logic [31:0] rd;
        addr_i = 32'd0; data_i = 32'd0; sel_i = 2'b11; rd_i = 1'b0; we_i = 1'b0; rxd_i = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", {31'd0, ack_o}, 32'd0);
        check("rst_data", data_o, 32'd0);
        check("rst_txd", {31'd0, txd_o}, 32'd1);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // TX framing of 0xA5
        push_frame(8'hA5);
        fork
            bus_write(TX_ADDR, 32'h0000_00A5, lat);
            tx_frames(1, s1);
        join
        check("tx_ack_lat", lat, 32'd2);
        check("tx_fall_time", s1, ack_cyc + 1);
        repeat (8) @(posedge clk);
        exp_q.push_back(32'h0000_0000);
        bus_read(TX_ADDR, rd);
        check_sb("tx_status_idle", rd);

        // back-to-back writes: third is stalled, frames run with no idle gap
        push_frame(8'h11); push_frame(8'h22); push_frame(8'h33);
        fork
            begin
                bus_write(TX_ADDR, 32'h0000_0011, l1);
                bus_write(TX_ADDR, 32'h0000_0022, l2);
                bus_write(TX_ADDR, 32'h0000_0033, l3);
                a3 = ack_cyc;
            end
            tx_frames(3, s1);
        join
        check("stall_lat1", l1, 32'd2);
        check("stall_lat2", l2, 32'd2);
        check("stall_ack3_time", a3, s1 + 10 * CLK_DIV + 1);
        repeat (20) @(posedge clk);

        // reset mid-transmit
        bus_write(TX_ADDR, 32'h0000_0055, lat);
        repeat (2) @(posedge clk); #3;
        check("pre_rst_txd", {31'd0, txd_o}, 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_txd", {31'd0, txd_o}, 32'd1);
        check("mid_rst_ack", {31'd0, ack_o}, 32'd0);
        repeat (3) @(posedge clk); #1;
        rst = 1'b1;
        exp_q.push_back(32'h0000_0000);
        bus_read(TX_ADDR, rd);
        check_sb("post_rst_status", rd);

`ifndef UART_LOOPBACK_EN
        // receive 0x3C; irq rises 79 cycles after the start edge (+/-1)
        @(posedge clk); #1;
        fork
            send_byte(8'h3C, 1'b1);
            begin
                lat = 0;
                while (lat < 300) begin
                    @(negedge clk); lat++;
                    if (irq_o) break;
                end
            end
        join
        check("rx_irq_lat_ok", {31'd0, (lat - 1 >= 78) && (lat - 1 <= 80)}, 32'd1);
        exp_q.push_back(32'h8000_003C);
        exp_q.push_back(32'h0000_0000);
        bus_read(RX_ADDR, rd); check_sb("rx_read1", rd);
        check("rx_irq_clear", {31'd0, irq_o}, 32'd0);
        bus_read(RX_ADDR, rd); check_sb("rx_read_empty", rd);

        // overflow: RX_DEPTH+1 bytes, last one lost
        for (int i = 1; i <= RX_DEPTH + 1; i++) send_byte(8'(i), 1'b1);
        exp_q.push_back(32'h0000_0400);
        exp_q.push_back(32'h8000_0201);
        for (int i = 2; i <= RX_DEPTH; i++) exp_q.push_back(32'h8000_0000 | 32'(i));
        exp_q.push_back(32'h0000_0000);
        bus_read(TX_ADDR, rd); check_sb("ovf_status", rd);
        for (int i = 0; i <= RX_DEPTH; i++) begin
            bus_read(RX_ADDR, rd);
            check_sb($sformatf("ovf_read%0d", i), rd);
        end

        // frame error: stop bit 0
        send_byte(8'h77, 1'b0);
        repeat (4) @(posedge clk);
        check("ferr_irq", {31'd0, irq_o}, 32'd0);
        exp_q.push_back(32'h0000_0100);
        exp_q.push_back(32'h0000_0000);
        bus_read(RX_ADDR, rd); check_sb("ferr_read", rd);
        bus_read(RX_ADDR, rd); check_sb("ferr_cleared", rd);
`else
        // loopback: transmitted byte comes back through the receiver
        bus_write(TX_ADDR, 32'h0000_005A, lat);
        repeat (12 * CLK_DIV) @(posedge clk);
        check("lb_irq", {31'd0, irq_o}, 32'd1);
        exp_q.push_back(32'h8000_005A);
        bus_read(RX_ADDR, rd); check_sb("lb_read", rd);
`endif

        check("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_ctrl.md
# uart_ctrl

Memory-mapped UART peripheral on the uart_* slave port of the system bus, serving the UART Rx word at 0xFFFF_FE08 and the UART Tx word at 0xFFFF_FE0C. It serialises CPU writes onto `txd_o` through a holding register and shifter. It deserialises `rxd_i` into a receive FIFO that the CPU drains by reading.

## Interface
- `CLK_DIV`, 434, clock cycles per bit (434 gives 115200 baud at 50 MHz); legal range 4..65535.
- `RX_DEPTH`, 16, RX FIFO entries; must be a power of 2, at least 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `addr_i`  in  32  bus address; only `addr_i[2]` is decoded (0 = RX word, 1 = TX word).
- `data_i`  in  32  write data; `[7:0]` is the TX byte.
- `data_o`  out  32  registered read data.
- `sel_i`  in  2  access size; ignored, because every access is treated as a full word.
- `rd_i`  in  1  read request; held by the master until `ack_o` is high.
- `we_i`  in  1  write request; held by the master until `ack_o` is high.
- `ack_o`  out  1  registered acknowledge.
- `rxd_i`  in  1  serial input, asynchronous to `clk`; idle level is 1.
- `txd_o`  out  1  serial output; idle level is 1.
- `irq_o`  out  1  high while the RX FIFO is non-empty.

## Operation
- **Reset values:** `ack_o`=0, `data_o`=0, `txd_o`=1 and `irq_o`=0.
  - The RX FIFO is empty, the TX holding register is empty, the sticky flags are 0, and both FSMs are in IDLE.
  - Assertion of `rst` aborts any frame in flight and forces `txd_o` to 1 immediately.
- **Accept rule:** a request is accepted in a cycle where `(rd_i|we_i) && !ack_o` holds and the request is not stalled.
  - Side effects (FIFO pop, TX load, flag clear) occur exactly once per accept.
- **RX read** (`addr_i[2]`=0):
  - `data_o` = {valid, 21'b0, overflow, frame_err, byte[7:0]}, with valid in bit 31, overflow in bit 9 and frame_err in bit 8.
  - If the FIFO is non-empty: pop one entry and return it with valid=1.
  - If the FIFO is empty: valid=0 and byte=0; nothing is popped.
  - The read clears both sticky flags. A flag set in the same cycle as the clear survives.
- **TX read** (`addr_i[2]`=1):
  - `data_o` = {16'b0, rx_count[7:0], 6'b0, shifter_busy, holding_full}, with rx_count in bits [15:8], shifter_busy in bit 1 and holding_full in bit 0.
  - The read has no side effects.
- **TX write:** load `data_i[7:0]` into the holding register.
  - While the holding register is full, the write is stalled: `ack_o` stays low and the master waits.
- **RX write:** acknowledged and ignored.
- **TX FSM:** IDLE → START → DATA → STOP → IDLE, with each state held for CLK_DIV cycles.
  - IDLE moves to START when the holding register is full; the holding register is moved into the shifter, which frees it.
  - Data is sent LSB first.
  - At the end of STOP, if the holding register is full, the FSM goes directly to START with no idle bit.
- **RX FSM:** `rxd_i` passes through a 2-flop synchroniser before use.
  - IDLE moves to START on a synchronised 1→0 transition.
  - At CLK_DIV/2 (floor) the line is sampled. If it is 1, the start is treated as a glitch and the FSM returns to IDLE. Otherwise it goes to DATA.
  - Eight bits are sampled, one every CLK_DIV cycles, LSB first, followed by STOP.
  - If the stop sample is 1, the byte is pushed to the FIFO. If the FIFO is full, the byte is dropped and overflow is set.
  - If the stop sample is 0, the byte is discarded and frame_err is set.
  - The FSM then returns to IDLE.
- **FIFO:** RX_DEPTH entries. rx_count is `$clog2(RX_DEPTH)+1` bits wide, zero-extended to 8 in the status word.
  - A push and a pop in the same cycle both occur and the count is unchanged.
  - A push in the same cycle as a pop of a full FIFO succeeds and does not set overflow.

## Timing
- Accept at cycle T → `ack_o`=1 and `data_o` valid from T+1.
- `ack_o` stays 1 while the request is held. It falls the cycle after the request drops; the fall is registered.
- A TX load at T makes `holding_full`=1 from T+1.
- The TX FSM leaves IDLE at T+1. `txd_o` falls at T+2.
- The total TX frame is 10×CLK_DIV cycles.
- RX latency: `irq_o` rises 2 (synchroniser) + 9.5×CLK_DIV + 1 cycles after the start edge on `rxd_i`, ±1 cycle.
- `irq_o` is registered from FIFO non-empty and updates one cycle after a push or pop.

## Configuration
- `UART_LOOPBACK_EN`:
  - **Defined:** the RX synchroniser input is `txd_o` instead of `rxd_i`, and `rxd_i` is unused. This is for self-test of the serial path.
  - **Undefined:** `rxd_i` drives the receiver and there is no loopback logic.

## Test plan
- **Reset state:** hold `rst`=0 mid-transmit → `txd_o`=1 and `ack_o`=0; after release, a TX read returns 0x0000_0000.
- **TX framing:** write 0x0000_00A5 with CLK_DIV=8 → `ack_o` at T+1; `txd_o` reads 0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles.
- **TX stall:** back-to-back writes 0x11, 0x22, 0x33 → the third write's ack is withheld until the 0x11 frame ends; the frames follow with no idle gap.
- **RX receive:** drive byte 0x3C on `rxd_i` → `irq_o`=1; an RX read returns 0x8000_003C; a second RX read returns 0x0000_0000; `irq_o` returns to 0.
- **RX errors:**
  - Send RX_DEPTH+1 bytes without reading → the first read returns bit 9=1 with the first byte; the RX_DEPTH+1th byte is lost.
  - Send a frame whose stop bit is 0 → frame_err=1 and the byte is discarded.
- **Loopback** (macro defined): write 0x5A → after the frame completes, an RX read returns 0x8000_005A.
